lock_controller: RTL
====================

# lock_controller

Central sequencer of the digital lock. Consumes debounced key events from the keypad scanner (`button`, `bstate`) and assembles entered digits into a code. Compares the code against the stored combination and drives the LED blinker through its start/done handshake to signal success or failure. Tracks consecutive failures, enforces a lockout period, and relocks automatically.

## Interface

Parameters:
- `CODE_LEN`, 4: digits per code, legal range 1..4.
- `CODE`, 16'h1234: reset combination, one nibble per digit, first digit in [15:12]. Only the top `CODE_LEN` nibbles are used.
- `MAX_FAILS`, 3: consecutive failures that trigger lockout.
- `LOCKOUT_CYCLES`, 24'd12_000_000: lockout duration in `hwclk` cycles.
- `ENTRY_TIMEOUT`, 24'd12_000_000: inactivity limit in ENTRY and UNLOCKED.

Ports:
- `hwclk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `button` in 4: key code from the scanner. 1..9 are valid digits; 0 and 10..15 are invalid.
- `bstate` in 1: high while a key is held. A key event is the falling edge of `bstate`.
- `done_blinking` in 1: high when the blinker is idle or has finished its pattern.
- `start_blinking` out 1: one-cycle request pulse to the blinker.
- `blinkType` out 1: pattern select, 0 = success, 1 = failure. Held stable from the start pulse until `done_blinking`.
- `unlocked` out 1: high in UNLOCKED.
- `locked_out` out 1: high in LOCKOUT.
- `digit_count` out 3: number of digits entered so far.

## Operation

- **Key event detection**
  - `bstate` is registered once.
  - A key event is previous = 1 and current = 0.
  - `button` is sampled in the same cycle as the event.
  - Events with an invalid code are ignored and do not restart the timeout.
- **IDLE**: a valid event stores the digit in the entry register, sets `digit_count` = 1, and moves to ENTRY.
- **ENTRY**
  - Each valid event shifts in a digit and increments `digit_count`.
  - When the count reaches `CODE_LEN`, the FSM moves to CHECK.
  - Inactivity of `ENTRY_TIMEOUT` cycles clears the entry and returns to IDLE. This does not count as a failure.
- **CHECK** (one cycle): compare the entry register with the stored code.
  - On match: clear the fail counter and go to BLINK_OK.
  - On mismatch: increment the fail counter (saturating at `MAX_FAILS`) and go to BLINK_FAIL.
  - `digit_count` returns to 0.
- **BLINK_OK / BLINK_FAIL**
  - Wait until `done_blinking` = 1.
  - Then pulse `start_blinking` for one cycle with `blinkType` set.
  - Then wait for `done_blinking` to rise after first being seen low, or for 2 cycles if it never drops.
  - After the blink: BLINK_OK goes to UNLOCKED. BLINK_FAIL goes to LOCKOUT if fails = `MAX_FAILS`, otherwise to IDLE.
- **UNLOCKED**
  - Any valid event relocks to IDLE; the digit is discarded.
  - An `ENTRY_TIMEOUT` of inactivity also relocks to IDLE.
- **LOCKOUT**
  - All key events are ignored.
  - After `LOCKOUT_CYCLES` cycles: clear the fail counter and go to IDLE.
- **Key handling outside entry states**: key events during CHECK or the blink states are dropped.
- **Timeout counter**: one shared down-counter, reloaded on every state entry and on every valid event.

## Timing

- **Reset values**
  - Outputs: `start_blinking`, `blinkType`, `unlocked`, `locked_out` = 0; `digit_count` = 0.
  - Internal: FSM in IDLE, fail counter 0, stored code = `CODE`.
- **Reset mid-operation**: reset in any state, including mid-blink or LOCKOUT, takes effect on the next edge. Any partial entry is discarded.
- **Digit latency**: a `bstate` falling edge at edge N+1 of the registered signal is captured at N+2, and `digit_count` updates at N+2.
- **Result latency**: from capture of the final digit, CHECK occupies 1 cycle. The earliest `start_blinking` is 2 cycles after capture.
- **Registered outputs**: all outputs are registered; none is combinational from inputs.
- **Timeout boundary**: if a valid event and timeout expiry occur in the same cycle, the event wins and the counter reloads.
- **Lockout boundary**: LOCKOUT exits exactly `LOCKOUT_CYCLES` cycles after entry.

## Configuration

- **`LOCK_PROGRAM_EN` defined**
  - In UNLOCKED, valid events are entered as a new code: `digit_count` advances and the FSM does not relock.
  - After `CODE_LEN` digits, the code register is overwritten, a success blink is issued, and the FSM returns to IDLE.
  - A timeout with a partial entry keeps the old code and relocks.
- **Undefined**
  - The code register is constant `CODE`.
  - Any valid event in UNLOCKED relocks.

## Test plan

- **Correct code**: reset, enter 1,2,3,4 -> `start_blinking` pulses once with `blinkType`=0; `unlocked`=1 after `done_blinking`; `digit_count` returns to 0.
- **Single failure**: enter 1,2,3,5 -> `blinkType`=1 pulse; return to IDLE; `unlocked`=0.
- **Lockout**: three wrong codes -> `locked_out`=1. Keys are ignored for exactly `LOCKOUT_CYCLES`. Then 1,2,3,4 unlocks.
- **Entry timeout and invalid keys**: enter 1,2, then idle for `ENTRY_TIMEOUT` -> `digit_count`=0 with no blink. Key code 0 or 12 is ignored.
- **Reset mid-operation**: assert `rst` during BLINK_FAIL and during LOCKOUT -> all outputs 0 next cycle; fail count cleared.
- **Programming mode**: with `LOCK_PROGRAM_EN`, unlock, enter 9,8,7,6 -> success blink. Then 1,2,3,4 fails and 9,8,7,6 unlocks.

Source files
------------

// File: rtl/lock_controller_if.sv
// Keypad / blinker signal bundle for lock_controller.
// The slave modport is the controller's view; the master modport is the
// view of the surrounding logic (keypad scanner plus LED blinker).
interface lock_controller_if;
  logic [3:0] button;          // key code from the scanner
  logic       bstate;          // high while a key is held
  logic       done_blinking;   // blinker idle / pattern finished
  logic       start_blinking;  // one-cycle blink request
  logic       blinkType;       // 0 = success pattern, 1 = failure pattern
  logic       unlocked;        // lock is open
  logic       locked_out;      // lockout period running
  logic [2:0] digit_count;     // digits entered so far

  modport slave (
    input  button,
    input  bstate,
    input  done_blinking,
    output start_blinking,
    output blinkType,
    output unlocked,
    output locked_out,
    output digit_count
  );

  modport master (
    output button,
    output bstate,
    output done_blinking,
    input  start_blinking,
    input  blinkType,
    input  unlocked,
    input  locked_out,
    input  digit_count
  );
endinterface

// File: rtl/lock_controller.sv
// lock_controller: central sequencer of the digital lock.
// Detects key releases, assembles digits into a code, compares it against the
// stored combination, drives the LED blinker handshake, counts consecutive
// failures, enforces a lockout period and relocks on inactivity.
//
// Optional feature: define LOCK_PROGRAM_EN to let the user enter a new
// combination while the lock is open. Without it the combination is the
// constant CODE parameter and any key press in UNLOCKED relocks.
module lock_controller #(
  parameter int unsigned CODE_LEN       = 4,
  parameter logic [15:0] CODE           = 16'h1234,
  parameter int unsigned MAX_FAILS      = 3,
  parameter logic [23:0] LOCKOUT_CYCLES = 24'd12_000_000,
  parameter logic [23:0] ENTRY_TIMEOUT  = 24'd12_000_000
) (
  input logic               hwclk,
  input logic               rst,
  lock_controller_if.slave  bus
);

  // Fail counter just wide enough to hold MAX_FAILS.
  localparam int unsigned FAIL_W = (MAX_FAILS < 2) ? 1 : $clog2(MAX_FAILS + 1);

  // Codes are kept right-aligned: the last digit entered sits in [3:0].
  localparam logic [15:0]       CODE_MASK = 16'hFFFF >> (4 * (4 - CODE_LEN));
  localparam logic [15:0]       CODE_INIT = CODE >> (4 * (4 - CODE_LEN));
  localparam logic [2:0]        LEN3      = 3'(CODE_LEN);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAILS);
  localparam logic [23:0]       TMO_LOAD  = ENTRY_TIMEOUT - 24'd1;
  localparam logic [23:0]       LCK_LOAD  = LOCKOUT_CYCLES - 24'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_BLINK_OK,
    S_BLINK_FAIL,
    S_UNLOCKED,
    S_LOCKOUT
  } state_e;

  // Blink handshake sub-phase: waiting for the blinker to be free, or
  // waiting for the requested pattern to finish.
  typedef enum logic {
    BP_WAIT,
    BP_ACTIVE
  } blink_phase_e;

  state_e            state_q, state_d;
  blink_phase_e      phase_q, phase_d;
  logic              bstate_q, bstate_d;
  logic              bstate_prev_q, bstate_prev_d;
  logic [15:0]       entry_q, entry_d;
  logic [2:0]        count_q, count_d;
  logic [FAIL_W-1:0] fails_q, fails_d;
  logic [23:0]       tmr_q, tmr_d;
  logic              start_q, start_d;
  logic              blink_type_q, blink_type_d;
  logic              unlocked_q, unlocked_d;
  logic              locked_out_q, locked_out_d;
  logic              seen_low_q, seen_low_d;
  logic              wait_q, wait_d;
  logic              prog_q, prog_d;
  logic [15:0]       code_cur;

`ifdef LOCK_PROGRAM_EN
  logic [15:0]       code_q, code_d;
  assign code_cur = code_q;
`else
  assign code_cur = CODE_INIT;
`endif

  // Key event: registered bstate falls; the key code is taken live that cycle.
  logic        key_event;
  logic        digit_ok;
  logic        valid_event;
  logic [15:0] entry_shift;
  logic [2:0]  count_inc;
  logic        blink_finished;

  assign key_event   = bstate_prev_q & ~bstate_q;
  assign digit_ok    = (bus.button >= 4'd1) && (bus.button <= 4'd9);
  assign valid_event = key_event & digit_ok;
  assign entry_shift = {entry_q[11:0], bus.button};
  assign count_inc   = count_q + 3'd1;

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    // NOTE: every *_d gets its hold/default value first so no path through
    // the case below leaves a variable unassigned, which would infer a latch.
    state_d        = state_q;
    phase_d        = phase_q;
    bstate_d       = bus.bstate;
    bstate_prev_d  = bstate_q;
    entry_d        = entry_q;
    count_d        = count_q;
    fails_d        = fails_q;
    tmr_d          = tmr_q;
    start_d        = 1'b0;
    blink_type_d   = blink_type_q;
    seen_low_d     = seen_low_q;
    wait_d         = wait_q;
    prog_d         = prog_q;
    blink_finished = 1'b0;
`ifdef LOCK_PROGRAM_EN
    code_d         = code_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (valid_event) begin
          entry_d = {12'h000, bus.button};
          count_d = 3'd1;
          state_d = (LEN3 == 3'd1) ? S_CHECK : S_ENTRY;
        end
      end

      S_ENTRY: begin
        // A key arriving in the expiry cycle wins over the timeout.
        if (valid_event) begin
          entry_d = entry_shift;
          count_d = count_inc;
          if (count_inc == LEN3) state_d = S_CHECK;
        end else if (tmr_q == 24'd0) begin
          entry_d = 16'h0000;
          count_d = 3'd0;
          state_d = S_IDLE;
        end
      end

      S_CHECK: begin
        count_d = 3'd0;
        entry_d = 16'h0000;
        if ((entry_q & CODE_MASK) == code_cur) begin
          fails_d = '0;
          state_d = S_BLINK_OK;
        end else begin
          if (fails_q != FAIL_MAX) fails_d = fails_q + FAIL_W'(1);
          state_d = S_BLINK_FAIL;
        end
      end

      S_BLINK_OK, S_BLINK_FAIL: begin
        if (phase_q == BP_WAIT) begin
          // Only request a pattern once the blinker reports itself free.
          if (bus.done_blinking) begin
            start_d      = 1'b1;
            blink_type_d = (state_q == S_BLINK_FAIL);
            phase_d      = BP_ACTIVE;
            seen_low_d   = 1'b0;
            wait_d       = 1'b0;
          end
        end else begin
          // Finish on done rising after a low, or after two cycles if the
          // blinker never drops done at all.
          wait_d = 1'b1;
          if (!bus.done_blinking) seen_low_d = 1'b1;
          else if (seen_low_q || wait_q) blink_finished = 1'b1;
        end

        if (blink_finished) begin
          phase_d = BP_WAIT;
          prog_d  = 1'b0;
          if (state_q == S_BLINK_OK) state_d = prog_q ? S_IDLE : S_UNLOCKED;
          else state_d = (fails_q == FAIL_MAX) ? S_LOCKOUT : S_IDLE;
        end
      end

      S_UNLOCKED: begin
`ifdef LOCK_PROGRAM_EN
        // Keys while open enter a new combination.
        if (valid_event) begin
          entry_d = entry_shift;
          count_d = count_inc;
          if (count_inc == LEN3) begin
            code_d  = entry_shift & CODE_MASK;
            entry_d = 16'h0000;
            count_d = 3'd0;
            prog_d  = 1'b1;
            state_d = S_BLINK_OK;
          end
        end else if (tmr_q == 24'd0) begin
          entry_d = 16'h0000;
          count_d = 3'd0;
          state_d = S_IDLE;
        end
`else
        // Any key relocks; the digit itself is discarded.
        if (valid_event || (tmr_q == 24'd0)) state_d = S_IDLE;
`endif
      end

      S_LOCKOUT: begin
        if (tmr_q == 24'd0) begin
          fails_d = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        phase_d = BP_WAIT;
      end
    endcase

    // Shared down-counter: reload on state entry and on accepted keys.
    if (state_d != state_q) begin
      tmr_d = (state_d == S_LOCKOUT) ? LCK_LOAD : TMO_LOAD;
    end else if (valid_event &&
                 (state_q == S_IDLE || state_q == S_ENTRY || state_q == S_UNLOCKED)) begin
      tmr_d = TMO_LOAD;
    end else if (tmr_q != 24'd0) begin
      tmr_d = tmr_q - 24'd1;
    end

    // Status outputs follow the next state so they are registered with it.
    unlocked_d   = (state_d == S_UNLOCKED);
    locked_out_d = (state_d == S_LOCKOUT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge hwclk) begin
    // NOTE: non-blocking assignments make every flop sample the values from
    // before this edge, so register order in this block does not matter.
    if (rst) begin
      state_q       <= S_IDLE;
      phase_q       <= BP_WAIT;
      bstate_q      <= 1'b0;
      bstate_prev_q <= 1'b0;
      entry_q       <= 16'h0000;
      count_q       <= 3'd0;
      fails_q       <= '0;
      tmr_q         <= 24'd0;
      start_q       <= 1'b0;
      blink_type_q  <= 1'b0;
      unlocked_q    <= 1'b0;
      locked_out_q  <= 1'b0;
      seen_low_q    <= 1'b0;
      wait_q        <= 1'b0;
      prog_q        <= 1'b0;
`ifdef LOCK_PROGRAM_EN
      code_q        <= CODE_INIT;
`endif
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      bstate_q      <= bstate_d;
      bstate_prev_q <= bstate_prev_d;
      entry_q       <= entry_d;
      count_q       <= count_d;
      fails_q       <= fails_d;
      tmr_q         <= tmr_d;
      start_q       <= start_d;
      blink_type_q  <= blink_type_d;
      unlocked_q    <= unlocked_d;
      locked_out_q  <= locked_out_d;
      seen_low_q    <= seen_low_d;
      wait_q        <= wait_d;
      prog_q        <= prog_d;
`ifdef LOCK_PROGRAM_EN
      code_q        <= code_d;
`endif
    end
  end

  assign bus.start_blinking = start_q;
  assign bus.blinkType      = blink_type_q;
  assign bus.unlocked       = unlocked_q;
  assign bus.locked_out     = locked_out_q;
  assign bus.digit_count    = count_q;

endmodule
